// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store sequencer:
// access sizes, AXI response codes and the controller state type.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_B      = 2'b00;
    localparam logic [1:0] SZ_H      = 2'b01;
    localparam logic [1:0] SZ_W      = 2'b10;
    localparam logic [1:0] SZ_X      = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RSP
    } lsu_state_e;

    // True for accesses that must be rejected without touching the bus.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_H:    bad = offset[0];
            SZ_W:    bad = (offset != 2'b00);
            SZ_X:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication and strobes, load extraction and
// sign/zero extension. Purely combinational.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (size)
            SZ_B: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << offset;
            end
            SZ_H: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << offset;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = load_word >> {offset, 3'b000};
        load_data = shifted;
        case (size)
            SZ_B: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Single-outstanding load/store sequencer from the memory stage to an
// AXI-lite data memory, with registered bus outputs and one-cycle response.
module dmem_lsu_ctrl
    import dmem_lsu_pkg::*;
#(
    parameter int AXI_AWIDTH = 10,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESETN,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [AXI_AWIDTH-1:0]     AXI_AWADDR,
    output logic                      AXI_AWVALID,
    input  logic                      AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]     AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0]   AXI_WSTRB,
    output logic                      AXI_WVALID,
    input  logic                      AXI_WREADY,
    input  logic [1:0]                AXI_BRESP,
    input  logic                      AXI_BVALID,
    output logic                      AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]     AXI_ARADDR,
    output logic                      AXI_ARVALID,
    input  logic                      AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]     AXI_RDATA,
    input  logic [1:0]                AXI_RRESP,
    input  logic                      AXI_RVALID,
    output logic                      AXI_RREADY
);

    lsu_state_e            state_q, state_d;
    logic [1:0]            size_q, size_d, offset_q, offset_d;
    logic                  unsigned_q, unsigned_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]           wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

    logic [1:0]            cur_size, cur_offset;
    logic [31:0]           lane_wdata, lane_load;
    logic [3:0]            lane_wstrb;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AXI_AWIDTH+2];

    // The aligner sees the live request while idle and the latched one afterwards.
    assign cur_size   = (state_q == ST_IDLE) ? req_size       : size_q;
    assign cur_offset = (state_q == ST_IDLE) ? req_addr[1:0]  : offset_q;

    lsu_lane_align u_align (
        .size        (cur_size),
        .offset      (cur_offset),
        .is_unsigned (unsigned_q),
        .store_data  (req_wdata),
        .load_word   (AXI_RDATA[31:0]),
        .wdata       (lane_wdata),
        .wstrb       (lane_wstrb),
        .load_data   (lane_load)
    );

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        offset_d    = offset_q;
        unsigned_d  = unsigned_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                size_d      = req_size;
                offset_d    = req_addr[1:0];
                unsigned_d  = req_unsigned;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0;
                if (is_bad_access(req_size, req_addr[1:0])) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (req_we) begin
                    state_d   = ST_WR_AW_W;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    awaddr_d  = req_addr[AXI_AWIDTH+1:2];
                    wdata_d   = lane_wdata;
                    wstrb_d   = lane_wstrb;
                end else begin
                    state_d   = ST_RD_ADDR;
                    arvalid_d = 1'b1;
                    rready_d  = 1'b1;
                    araddr_d  = req_addr[AXI_AWIDTH+1:2];
                end
            end
            // AW and W complete independently; move on once neither is pending.
            ST_WR_AW_W: begin
                if (awvalid_q && AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)  state_d   = ST_WR_RESP;
            end
            ST_WR_RESP: if (AXI_BVALID) begin
                bready_d    = 1'b0;
                rsp_err_d   = (AXI_BRESP != RESP_OKAY);
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RD_ADDR: if (AXI_ARREADY) begin
                arvalid_d = 1'b0;
                state_d   = ST_RD_DATA;
            end
            ST_RD_DATA: if (AXI_RVALID) begin
                rready_d    = 1'b0;
                rsp_rdata_d = lane_load;
                rsp_err_d   = (AXI_RRESP != RESP_OKAY);
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_B;
            offset_q    <= 2'b00;
            unsigned_q  <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            offset_q    <= offset_d;
            unsigned_q  <= unsigned_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign AXI_AWADDR  = awaddr_q;
    assign AXI_AWVALID = awvalid_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = wstrb_q;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_BREADY  = bready_q;
    assign AXI_ARADDR  = araddr_q;
    assign AXI_ARVALID = arvalid_q;
    assign AXI_RREADY  = rready_q;

endmodule
